fp_normalizer: RTL and testbench
================================

# fp_normalizer

Post-add normalizer and rounder for the floating-point adder datapath. It sits downstream of the alignment right-shifter and mantissa adder, and works in the opposite direction to alignment. It takes a raw mantissa sum, with carry bit, hidden bit and fraction, plus the round/sticky bits produced by alignment. It then renormalizes the sum iteratively, one bit position per cycle, adjusting the exponent as it goes. Finally it applies round-to-nearest-even and emits a packed fraction/exponent over a valid/ready handshake.

## Interface
Parameters:
- n, 23: fraction width.
- exp, 8: exponent width.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand present.
- in_ready  out  1  block can accept an operand; high only in IDLE, low while rst_n low.
- in_mant  in  n+2  raw sum: bit n+1 = carry-out, bit n = hidden bit, [n-1:0] = fraction.
- in_exp  in  exp  biased exponent of the sum.
- in_sign  in  1  result sign, passed through.
- in_round  in  1  round (guard) bit from alignment.
- in_sticky  in  1  sticky bit from alignment.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_mant  out  n  rounded fraction (hidden bit dropped).
- out_exp  out  exp  final biased exponent.
- out_sign  out  1  registered in_sign.
- out_zero  out  1  exact-zero result.
- out_overflow  out  1  result overflowed to infinity.

## Operation
- Internal registers: mant[n+1:0], e[exp-1:0], r, s, sign, zero, ovf.
- FSM states: IDLE, NORM, ROUND, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: load all input registers and go to NORM.
- **NORM**: exactly one of the following actions per cycle, evaluated in this priority order.
  1. mant == 0 && r == 0 && s == 0: set zero = 1, set e = 0, go to DONE.
  2. mant[n+1] = 1: right shift by 1. Update s <= s | r, r <= mant[0], mant <= mant >> 1, e <= e + 1. Go to ROUND.
  3. mant[n] = 1: go to ROUND.
  4. e <= 1: set e = 0 (subnormal) with mant unchanged. Go to ROUND.
  5. Otherwise: left shift by 1. Update mant <= {mant[n:0], r}, r <= 0, s unchanged, e <= e - 1. Stay in NORM.
- **ROUND**
  - inc = r & (s | mant[0]); mant <= mant + inc.
  - If the increment carries into bit n+1: shift right 1 and set e + 1.
  - If e == 0 and the increment sets bit n: e <= 1.
  - If the final e == all-ones: ovf = 1, fraction forced to 0, e = all-ones.
  - Go to DONE.
- **DONE**
  - out_valid = 1. out_mant = mant[n-1:0]; out_exp, out_sign, out_zero and out_overflow come from the registers.
  - On out_ready: go to IDLE. Outputs hold stable while out_ready = 0.
- Exponent arithmetic is modulo 2^exp internally. In practice, wrap is prevented by the e <= 1 stop rule and the overflow rule.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - out_valid, out_mant, out_exp, out_sign, out_zero and out_overflow are all 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
  - An in-flight operand is discarded.
- Latency, counted from the accept edge:
  - Already-normalized or carry input: out_valid rises 3 edges later (NORM, ROUND, DONE).
  - Each left shift adds 1 cycle; the maximum is n+1 extra cycles.
- Throughput: one operand per (latency + 1) cycles minimum. There is no overlap; in_ready is 0 from NORM through DONE.
- in_valid is ignored outside IDLE.
- A result is transferred on the edge where out_valid && out_ready. in_ready goes high the following cycle.

## Test plan
1. **Already normalized.** in_mant=0x0800000, in_exp=0x7F, round=0, sticky=0 -> out_mant=0x000000, out_exp=0x7F, out_zero=0, out_valid 3 cycles after accept.
2. **Carry-out, RNE tie.** in_mant=0x1000001, in_exp=0x80, r=s=0 -> right shift yields r=1, s=0, lsb=0, so no increment. Expect out_mant=0x000000, out_exp=0x81.
3. **Left shift by 3.** in_mant=0x0100000, in_exp=0x10, in_round=1 -> out_mant=0x000004, out_exp=0x0D, out_valid 6 cycles after accept.
4. **Underflow to subnormal.** in_mant=0x0000100, in_exp=0x03 -> two shifts, then e forced to 0. Expect out_mant=0x000400, out_exp=0x00, out_overflow=0.
5. **Rounding overflow.** in_mant=0x0FFFFFF, in_exp=0xFE, r=s=1 -> increment carries and e becomes 0xFF. Expect out_overflow=1, out_mant=0, out_exp=0xFF.
6. **Zero, backpressure and reset.**
   - in_mant=0, r=s=0 -> out_zero=1, out_exp=0.
   - With out_ready=0 for 5 cycles: outputs stay stable and in_ready stays 0.
   - A second operand with rst_n pulsed low during NORM -> all outputs 0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle between the mantissa adder and the post-add normalizer.
// Signal names follow the adder datapath naming; modports fix the direction per side.
interface fp_normalizer_if #(
    parameter int n   = 23,
    parameter int exp = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [n+1:0]   in_mant;
    logic [exp-1:0] in_exp;
    logic           in_sign;
    logic           in_round;
    logic           in_sticky;
    logic           out_valid;
    logic           out_ready;
    logic [n-1:0]   out_mant;
    logic [exp-1:0] out_exp;
    logic           out_sign;
    logic           out_zero;
    logic           out_overflow;

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, in_round, in_sticky, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_overflow
    );

    modport master (
        output in_valid, in_mant, in_exp, in_sign, in_round, in_sticky, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_overflow
    );
endinterface

// File: rtl/fp_normalizer.sv
// Post-add normalizer/rounder: renormalizes a raw mantissa sum one bit per cycle,
// then applies round-to-nearest-even and presents the packed result over valid/ready.
module fp_normalizer #(
    parameter int n   = 23,
    parameter int exp = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_normalizer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t         state_q, state_d;
    logic [n+1:0]   mant_q, mant_d;
    logic [exp-1:0] e_q, e_d;
    logic           r_q, r_d, s_q, s_d;
    logic           sign_q, sign_d, zero_q, zero_d, ovf_q, ovf_d;

    logic           norm_zero, norm_stop;
    logic           inc;
    logic [n+1:0]   sum;
    logic [exp-1:0] e_rnd;

    assign norm_zero = (mant_q == '0) && !r_q && !s_q;
    // Shifting stops on carry, on a set hidden bit, or when the exponent bottoms out.
    assign norm_stop = mant_q[n+1] || mant_q[n] || (e_q <= exp'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = NORM;
            NORM:    if (norm_zero) state_d = DONE;
                     else if (norm_stop) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rst_n;
        bus.out_valid = (state_q == DONE);
    end

    always_comb begin
        mant_d = mant_q;
        e_d    = e_q;
        r_d    = r_q;
        s_d    = s_q;
        sign_d = sign_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        inc    = 1'b0;
        sum    = '0;
        e_rnd  = e_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                mant_d = bus.in_mant;
                e_d    = bus.in_exp;
                r_d    = bus.in_round;
                s_d    = bus.in_sticky;
                sign_d = bus.in_sign;
                zero_d = 1'b0;
                ovf_d  = 1'b0;
            end
            NORM: begin
                if (norm_zero) begin
                    zero_d = 1'b1;
                    e_d    = '0;
                end else if (mant_q[n+1]) begin
                    s_d    = s_q | r_q;
                    r_d    = mant_q[0];
                    mant_d = mant_q >> 1;
                    e_d    = e_q + exp'(1);
                end else if (mant_q[n]) begin
                    mant_d = mant_q;
                end else if (e_q <= exp'(1)) begin
                    e_d = '0;
                end else begin
                    mant_d = {mant_q[n:0], r_q};
                    r_d    = 1'b0;
                    e_d    = e_q - exp'(1);
                end
            end
            ROUND: begin
                inc    = r_q & (s_q | mant_q[0]);
                sum    = mant_q + {{(n+1){1'b0}}, inc};
                mant_d = sum;
                if (sum[n+1]) begin
                    mant_d = sum >> 1;
                    e_rnd  = e_q + exp'(1);
                end else if ((e_q == '0) && !mant_q[n] && sum[n]) begin
                    // Subnormal rounded up into the normal range.
                    e_rnd = exp'(1);
                end
                e_d = e_rnd;
                if (&e_rnd) begin
                    ovf_d          = 1'b1;
                    mant_d[n-1:0]  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q <= '0;
            e_q    <= '0;
            r_q    <= 1'b0;
            s_q    <= 1'b0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            mant_q <= mant_d;
            e_q    <= e_d;
            r_q    <= r_d;
            s_q    <= s_d;
            sign_q <= sign_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_mant     = mant_q[n-1:0];
    assign bus.out_exp      = e_q;
    assign bus.out_sign     = sign_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed corner cases plus randomized operands.
module tb_fp_normalizer;
    localparam int N = 23;
    localparam int E = 8;

    typedef struct {
        logic [N-1:0] mant;
        logic [E-1:0] e;
        logic         sign;
        logic         zero;
        logic         ovf;
        int           lat;
    } res_t;

    logic clk, rst_n;
    int   n_cmp, n_err;
    res_t sb[$];

    fp_normalizer_if #(.n(N), .exp(E)) bus ();
    fp_normalizer #(.n(N), .exp(E)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic res_t mk(input logic [N-1:0] m, input logic [E-1:0] e, input logic sg,
                                input logic z, input logic o, input int lat);
        res_t x;
        x.mant = m; x.e = e; x.sign = sg; x.zero = z; x.ovf = o; x.lat = lat;
        return x;
    endfunction

    // Reference behaviour: normalize, then round-to-nearest-even.
    function automatic res_t model(input logic [N+1:0] m_in, input logic [E-1:0] e_in,
                                   input logic sg, input logic r_in, input logic s_in);
        res_t x;
        logic [N+1:0] m, sum;
        logic [E-1:0] e;
        logic r, s, inc;
        bit stop;
        int k;
        m = m_in; e = e_in; r = r_in; s = s_in; stop = 0; k = 0;
        x.sign = sg; x.zero = 0; x.ovf = 0;
        while (!stop) begin
            if (m == 0 && !r && !s) begin
                x.zero = 1; x.mant = '0; x.e = '0; x.lat = 2 + k;
                return x;
            end else if (m[N+1]) begin
                s = s | r; r = m[0]; m = m >> 1; e = e + 1; stop = 1;
            end else if (m[N]) begin
                stop = 1;
            end else if (e <= 1) begin
                e = '0; stop = 1;
            end else begin
                m = {m[N:0], r}; r = 0; e = e - 1; k++;
            end
        end
        inc = r & (s | m[0]);
        sum = m + {{(N+1){1'b0}}, inc};
        if (sum[N+1]) begin
            sum = sum >> 1; e = e + 1;
        end else if (e == 0 && !m[N] && sum[N]) begin
            e = 1;
        end
        if (&e) begin
            x.ovf = 1; sum[N-1:0] = '0;
        end
        x.mant = sum[N-1:0]; x.e = e; x.lat = k + 3;
        return x;
    endfunction

    task automatic do_op(input string tag, input logic [N+1:0] m, input logic [E-1:0] e,
                         input logic sg, input logic r, input logic s, input res_t ex,
                         input bit hold);
        res_t got;
        int lat, w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        if (!bus.in_ready) begin chk({tag, "_rdy_timeout"}, 0, 1); return; end
        bus.in_mant = m; bus.in_exp = e; bus.in_sign = sg;
        bus.in_round = r; bus.in_sticky = s; bus.in_valid = 1'b1;
        sb.push_back(ex);
        @(posedge clk); lat = 1;
        #1 bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); lat++; #1; end
        got = sb.pop_front();
        if (!bus.out_valid) begin chk({tag, "_vld_timeout"}, 0, 1); return; end
        chk({tag, "_mant"}, 32'(bus.out_mant), 32'(got.mant));
        chk({tag, "_exp"},  32'(bus.out_exp),  32'(got.e));
        chk({tag, "_sign"}, 32'(bus.out_sign), 32'(got.sign));
        chk({tag, "_zero"}, 32'(bus.out_zero), 32'(got.zero));
        chk({tag, "_ovf"},  32'(bus.out_overflow), 32'(got.ovf));
        chk({tag, "_lat"},  32'(lat), 32'(got.lat));
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                chk({tag, "_hold_vld"},  32'(bus.out_valid), 1);
                chk({tag, "_hold_mant"}, 32'(bus.out_mant), 32'(got.mant));
                chk({tag, "_hold_zero"}, 32'(bus.out_zero), 32'(got.zero));
                chk({tag, "_hold_rdy"},  32'(bus.in_ready), 0);
            end
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        chk({tag, "_vld_clr"}, 32'(bus.out_valid), 0);
        chk({tag, "_rdy_back"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [N+1:0] rm;
        logic [E-1:0] re;
        logic rsg, rr, rs;
        n_cmp = 0; n_err = 0;
        bus.in_valid = 0; bus.in_mant = '0; bus.in_exp = '0; bus.in_sign = 0;
        bus.in_round = 0; bus.in_sticky = 0; bus.out_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_mant", 32'(bus.out_mant), 0);
        chk("rst_out_exp", 32'(bus.out_exp), 0);
        chk("rst_out_ovf", 32'(bus.out_overflow), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(bus.in_ready), 1);

        do_op("t1_norm",  25'h0800000, 8'h7F, 0, 0, 0, mk(23'h000000, 8'h7F, 0, 0, 0, 3), 0);
        do_op("t2_carry", 25'h1000001, 8'h80, 1, 0, 0, mk(23'h000000, 8'h81, 1, 0, 0, 3), 0);
        do_op("t3_lsh3",  25'h0100000, 8'h10, 0, 1, 0, mk(23'h000004, 8'h0D, 0, 0, 0, 6), 0);
        do_op("t4_subn",  25'h0000100, 8'h03, 0, 0, 0, mk(23'h000400, 8'h00, 0, 0, 0, 5), 0);
        do_op("t5_ovf",   25'h0FFFFFF, 8'hFE, 0, 1, 1, mk(23'h000000, 8'hFF, 0, 0, 1, 3), 0);
        do_op("t6_zero",  25'h0000000, 8'h44, 1, 0, 0, mk(23'h000000, 8'h00, 1, 1, 0, 2), 1);
        do_op("t7_rne_up", 25'h0800001, 8'h20, 0, 1, 0, mk(23'h000002, 8'h20, 0, 0, 0, 3), 0);

        // Reset pulse while a long normalization is in flight.
        @(negedge clk);
        bus.in_mant = 25'h0000001; bus.in_exp = 8'h80; bus.in_sign = 1;
        bus.in_round = 0; bus.in_sticky = 0; bus.in_valid = 1;
        @(posedge clk); #1 bus.in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_mant", 32'(bus.out_mant), 0);
        chk("mid_rst_exp", 32'(bus.out_exp), 0);
        chk("mid_rst_sign", 32'(bus.out_sign), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("mid_rel_ready", 32'(bus.in_ready), 1);
        chk("mid_rel_valid", 32'(bus.out_valid), 0);

        do_op("t8_after_rst", 25'h0800000, 8'h7F, 0, 0, 0, mk(23'h000000, 8'h7F, 0, 0, 0, 3), 0);

        for (int i = 0; i < 30; i++) begin
            rm = 25'($urandom) & 25'h0FFFFFF;
            rm = rm >> $urandom_range(0, 24);
            if ($urandom_range(0, 3) == 0) rm[N+1] = 1'b1;
            re  = E'($urandom_range(0, 254));
            rsg = 1'($urandom); rr = 1'($urandom); rs = 1'($urandom);
            do_op($sformatf("rnd%0d", i), rm, re, rsg, rr, rs, model(rm, re, rsg, rr, rs), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
